// File: rtl/config_load_sequencer.sv
// Serial configuration loader for the TDC chip: snapshots the register bank and shifts it out
// as a framed load (reset pulse, sck/sda bit stream, capture strobe) on power-up, request or refresh.
module config_load_sequencer #(
    parameter int unsigned NBYTES         = 13,
    parameter int unsigned SCK_DIV        = 8,
    parameter int unsigned RESET_CYCLES   = 16,
    parameter int unsigned REFRESH_PERIOD = 1048576
) (
    input  logic                  clkin,
    input  logic                  rst_n,
    input  logic [NBYTES*8-1:0]   cfg_data,
    input  logic                  cfg_update,
    input  logic                  comm_busy,
    input  logic                  refresh_en,
    output logic                  p_sck,
    output logic                  p_sda,
    output logic                  p_scapt,
    output logic                  p_reset,
    output logic                  busy,
    output logic                  done,
    output logic [7:0]            load_count
);

    localparam int unsigned NBITS = NBYTES * 8;
    localparam int unsigned MAXC  = (SCK_DIV > RESET_CYCLES) ? SCK_DIV : RESET_CYCLES;
    localparam int unsigned CW    = (MAXC > 1) ? $clog2(MAXC) : 1;
    localparam int unsigned BW    = $clog2(NBITS + 1);
    localparam int unsigned TW    = $clog2(REFRESH_PERIOD);

    typedef enum logic [2:0] {
        StIdle,
        StReset,
        StShiftLo,
        StShiftHi,
        StCapture,
        StDone
    } state_e;

    state_e           state_q, state_d;
    logic [CW-1:0]    cyc_q, cyc_d;
    logic [BW-1:0]    bits_q, bits_d;
    logic [NBITS-1:0] sreg_q, sreg_d;
    logic [NBITS-1:0] snap;
    logic [TW-1:0]    timer_q, timer_d;
    logic             pending_q, pending_d;
    logic [7:0]       count_q, count_d;

    logic             start;
    logic             expire;
    logic             div_end;
    logic             rst_end;

    logic             sck_d, sda_d, scapt_d, reset_d, busy_d, done_d;

    // Byte 0 goes to the top of the shift register so its bit 7 leaves first.
    always_comb begin
        snap = '0;
        for (int unsigned i = 0; i < NBYTES; i++) begin
            snap[(NBYTES-1-i)*8 +: 8] = cfg_data[i*8 +: 8];
        end
    end

    assign start   = (state_q == StIdle) && pending_q && !comm_busy;
    assign expire  = (state_q == StIdle) && refresh_en && (timer_q == TW'(REFRESH_PERIOD - 1));
    assign div_end = (cyc_q == CW'(SCK_DIV - 1));
    assign rst_end = (cyc_q == CW'(RESET_CYCLES - 1));

    // A start swallows any request arriving in the same cycle: it is already being served.
    always_comb begin
        pending_d = pending_q | cfg_update | expire;
        if (start) begin
            pending_d = 1'b0;
        end
    end

    always_comb begin
        timer_d = timer_q;
        if (start) begin
            timer_d = '0;
        end else if (state_q == StIdle && refresh_en) begin
            timer_d = expire ? '0 : timer_q + TW'(1);
        end
    end

    always_comb begin
        state_d = state_q;
        cyc_d   = cyc_q;
        bits_d  = bits_q;
        sreg_d  = sreg_q;
        count_d = count_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StReset;
                    cyc_d   = '0;
                    bits_d  = BW'(NBITS);
                    sreg_d  = snap;
                end
            end
            StReset: begin
                if (rst_end) begin
                    state_d = StShiftLo;
                    cyc_d   = '0;
                end else begin
                    cyc_d = cyc_q + CW'(1);
                end
            end
            StShiftLo: begin
                if (div_end) begin
                    state_d = StShiftHi;
                    cyc_d   = '0;
                end else begin
                    cyc_d = cyc_q + CW'(1);
                end
            end
            StShiftHi: begin
                if (div_end) begin
                    cyc_d   = '0;
                    bits_d  = bits_q - BW'(1);
                    sreg_d  = sreg_q << 1;
                    state_d = (bits_q == BW'(1)) ? StCapture : StShiftLo;
                end else begin
                    cyc_d = cyc_q + CW'(1);
                end
            end
            StCapture: begin
                if (div_end) begin
                    state_d = StDone;
                    cyc_d   = '0;
                    count_d = count_q + 8'd1;
                end else begin
                    cyc_d = cyc_q + CW'(1);
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Pad outputs are decoded from the next state and registered, so they change cleanly
    // on the same edge as the state they describe.
    always_comb begin
        sck_d   = (state_d == StShiftHi);
        sda_d   = ((state_d == StShiftLo) || (state_d == StShiftHi)) ? sreg_d[NBITS-1] : 1'b0;
        scapt_d = (state_d == StCapture);
        reset_d = (state_d == StReset);
        busy_d  = (state_d != StIdle);
        done_d  = (state_d == StDone);
    end

    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            cyc_q     <= '0;
            bits_q    <= '0;
            sreg_q    <= '0;
            timer_q   <= '0;
            pending_q <= 1'b1;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            cyc_q     <= cyc_d;
            bits_q    <= bits_d;
            sreg_q    <= sreg_d;
            timer_q   <= timer_d;
            pending_q <= pending_d;
            count_q   <= count_d;
        end
    end

    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            p_sck   <= 1'b0;
            p_sda   <= 1'b0;
            p_scapt <= 1'b0;
            p_reset <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            p_sck   <= sck_d;
            p_sda   <= sda_d;
            p_scapt <= scapt_d;
            p_reset <= reset_d;
            busy    <= busy_d;
            done    <= done_d;
        end
    end

    assign load_count = count_q;

endmodule

// File: doc/config_load_sequencer.md
# config_load_sequencer

Sequencer that owns the serial configuration port of the TDC chip. It snapshots the I2C-written configuration register bank and shifts it out as a framed load: reset pulse, bit-serial data on sck/sda, then a capture strobe. Loads are scheduled from three sources: a power-up load, host update requests, and an optional periodic refresh that rewrites the chip configuration against upsets. It sits between the communication controller's register outputs and the inverting pad drivers at the top level.

## Interface
- NBYTES, 13, number of configuration bytes per load
- SCK_DIV, 8, clkin cycles per sck half-period (>=1)
- RESET_CYCLES, 16, clkin cycles p_reset is held high per load (>=1)
- REFRESH_PERIOD, 1048576, idle clkin cycles between automatic refresh loads (>=2)
- clkin  in  1  system clock; one clock, all logic on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- cfg_data  in  NBYTES*8  flattened register bank; byte 0 (first register) in [7:0]
- cfg_update  in  1  single-cycle request to load; any high cycle counts
- comm_busy  in  1  host bus activity; new loads must not start while high
- refresh_en  in  1  enables the periodic refresh timer
- p_sck  out  1  serial clock to chip, true polarity
- p_sda  out  1  serial data to chip, true polarity
- p_scapt  out  1  capture strobe, true polarity
- p_reset  out  1  chip config reset, true polarity
- busy  out  1  high from the first RESET cycle through the DONE cycle
- done  out  1  one-cycle pulse in the DONE state
- load_count  out  8  completed loads, wraps 255->0

## Operation
- States: IDLE, RESET, SHIFT_LO, SHIFT_HI, CAPTURE, DONE.
- pending flag: resets to 1 (power-up load). Set by cfg_update, or by refresh timer expiry. Cleared on the IDLE->RESET transition only.
- IDLE -> RESET when pending=1 and comm_busy=0. On that edge the shift register loads cfg_data, the bit counter loads NBYTES*8, and the refresh timer clears.
- RESET: p_reset=1 for RESET_CYCLES cycles, then -> SHIFT_LO.
- Bit order: byte 0 bit 7 first, down to byte 0 bit 0, then byte 1 bit 7 ... byte NBYTES-1 bit 0 last.
- SHIFT_LO: p_sck=0 and p_sda=current bit, for SCK_DIV cycles, then -> SHIFT_HI.
- SHIFT_HI: p_sck=1 and p_sda held, for SCK_DIV cycles. Then the bit counter decrements; -> SHIFT_LO if bits remain, else -> CAPTURE.
- CAPTURE: p_sck=0, p_sda=0, p_scapt=1 for SCK_DIV cycles, then -> DONE.
- DONE: done=1 for one cycle, load_count increments, then -> IDLE.
- Refresh timer counts only in IDLE with refresh_en=1. It holds its value when refresh_en=0. On reaching REFRESH_PERIOD-1 it sets pending and wraps to 0.
- cfg_data changes after the snapshot do not affect the load in progress.
- comm_busy rising during a load is ignored; the load completes.
- cfg_update arriving in any non-IDLE state, including DONE, sets pending, so exactly one further load follows.
- cfg_update and timer expiry in the same cycle produce one pending and one load.
- Any number of requests while pending=1 produce one load.

## Timing
- Reset values: p_sck=0, p_sda=0, p_scapt=0, p_reset=0, busy=0, done=0, load_count=0. Internally: state=IDLE, timer=0, pending=1.
- rst_n low mid-load forces the reset values asynchronously and aborts the load with no done pulse. Because pending=1 after reset, a fresh load follows.
- All outputs are registered and glitch-free.
- Start latency: 1 cycle from pending=1 and comm_busy=0 to the first p_reset=1 and busy=1 cycle.
- Load duration with busy=1: RESET_CYCLES + NBYTES*8*2*SCK_DIV + SCK_DIV + 1 cycles. With defaults this is 16+1664+8+1 = 1689 cycles.
- p_sda is stable for a full SCK_DIV cycles before each p_sck rising edge and for SCK_DIV cycles after it.
- Back-to-back loads: minimum one IDLE cycle (busy=0) between DONE and the next RESET.

## Test plan
- Power-up: release rst_n with comm_busy=0 and cfg_data=0x..A5 (byte0=0xA5). Required: busy rises 1 cycle later, p_reset high for 16 cycles, first 8 sampled bits on p_sck rising edges are 1,0,1,0,0,1,0,1, 104 rising edges total, p_scapt high for 8 cycles, done at cycle 1689, load_count=1.
- comm_busy gating: hold comm_busy=1 for 500 cycles after reset. Required: no busy until comm_busy falls, then RESET starts 1 cycle later. Pulse comm_busy mid-shift: load completes unchanged.
- Coalescing: 3 cfg_update pulses during a load plus one in the DONE cycle. Required: exactly one extra load, load_count +2 total.
- Refresh: set REFRESH_PERIOD=100 with refresh_en=1 and idle. Required: a load starts 101 cycles after entering IDLE. With refresh_en=0: no load for 10000 cycles.
- Snapshot: change cfg_data byte0 from 0xFF to 0x00 during the RESET state. Required: shifted byte0 bits are all 1.
- Abort: assert rst_n low at bit 50. Required: all outputs 0 immediately, no done pulse, and after release a full 104-bit load with load_count ending at 1.
